// File: rtl/led_counter_pkg.sv
// Shared constants and FSM encoding for the LED row sequencer of the led_counter design.
package led_counter_pkg;

    localparam int N_LEDS  = 13;
    localparam int X0      = 32;
    localparam int Y0      = 96;
    localparam int SPR_W   = 32;
    localparam int SPR_H   = 32;

    localparam int R_W     = 5;
    localparam int G_W     = 6;
    localparam int B_W     = 5;
    localparam int RGB_W   = R_W + G_W + B_W;

    localparam int COORD_W = 9;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_SCAN = 2'd2
    } row_state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous reset; aligns side-band bits with ROM latency.
module pipe_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [DEPTH-1:0][W-1:0] stage;

    // Shift d through DEPTH stages, clearing every stage on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/led_row_sequencer.sv
// Scans a row of LED sprite slots: ROM addressing, slot tracking, on/off sprite select, latency alignment.
module led_row_sequencer #(
    parameter int N_LEDS  = led_counter_pkg::N_LEDS,
    parameter int X0      = led_counter_pkg::X0,
    parameter int Y0      = led_counter_pkg::Y0,
    parameter int ROM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [8:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_de,
    input  logic              i_frame_start,
    input  logic [N_LEDS-1:0] i_status,
    input  logic              i_lamp_test,
    output logic [9:0]        o_rom_addr,
    input  logic [15:0]       i_rom_on,
    input  logic [15:0]       i_rom_off,
    output logic              o_de,
    output logic [4:0]        o_r,
    output logic [5:0]        o_g,
    output logic [4:0]        o_b
);

    import led_counter_pkg::*;

    localparam int SLOT_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    // One extra bit so the exclusive end bounds never wrap.
    localparam logic [9:0] X0_C   = 10'(X0);
    localparam logic [9:0] XEND_C = 10'(X0 + SPR_W * N_LEDS);
    localparam logic [9:0] Y0_C   = 10'(Y0);
    localparam logic [9:0] YEND_C = 10'(Y0 + SPR_H);

    row_state_t        state;
    logic [SLOT_W-1:0] slot;
    logic [N_LEDS-1:0] shadow;

    logic in_band, in_cols, at_x0, at_last;
    logic scan_now, lit_now;
    logic de_d, win_d, lit_d;
    logic [15:0] pix_sel;

    // Sprite-local address; x0/y0 sit on 32-pixel boundaries so the low bits index the sprite directly.
    assign o_rom_addr = {i_y[4:0], i_x[4:0]};

    assign in_band = ({1'b0, i_y} >= Y0_C) && ({1'b0, i_y} < YEND_C);
    assign in_cols = ({1'b0, i_x} >= X0_C) && ({1'b0, i_x} < XEND_C);
    assign at_x0   = ({1'b0, i_x} == X0_C);
    assign at_last = ({1'b0, i_x} == XEND_C - 10'd1);

    // A pixel is drawn only while a properly started scan is running; after a DE gap or a
    // mid-line reset the line stays black because the slot count can no longer be trusted.
    assign scan_now = in_band && in_cols && i_de &&
                      ((state == S_SCAN) || ((state == S_ROW) && at_x0));
    assign lit_now  = shadow[slot];

    // Row FSM and slot counter; slot restarts at 0 on every return to S_ROW.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            slot  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    slot <= '0;
                    if (in_band) state <= S_ROW;
                end
                S_ROW: begin
                    slot <= '0;
                    if (!in_band)          state <= S_IDLE;
                    else if (at_x0 && i_de) state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!in_band) begin
                        state <= S_IDLE;
                        slot  <= '0;
                    end else if (at_last || !i_de) begin
                        state <= S_ROW;
                        slot  <= '0;
                    end else if (i_x[4:0] == 5'd31) begin
                        slot <= slot + SLOT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    slot  <= '0;
                end
            endcase
        end
    end

    // Frame-stable copy of the LED status so a mid-frame change cannot tear the row.
    always_ff @(posedge i_clk) begin
        if (i_rst)              shadow <= '0;
        else if (i_frame_start) shadow <= i_status;
    end

    pipe_delay #(
        .W     (3),
        .DEPTH (ROM_LAT)
    ) u_align (
        .clk (i_clk),
        .rst (i_rst),
        .d   ({i_de, scan_now, lit_now}),
        .q   ({de_d, win_d, lit_d})
    );

    // Sprite select; lamp test is live rather than shadowed.
    always_comb begin
        pix_sel = i_rom_off;
        if (i_lamp_test || lit_d) pix_sel = i_rom_on;
    end

    // Registered colour and DE outputs, black outside the scanned window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_de <= 1'b0;
            o_r  <= '0;
            o_g  <= '0;
            o_b  <= '0;
        end else begin
            o_de <= de_d;
            if (win_d) begin
                o_r <= pix_sel[15:11];
                o_g <= pix_sel[10:5];
                o_b <= pix_sel[4:0];
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_led_row_sequencer.sv
// Directed bench for led_row_sequencer: full-line pixel checks against a behavioural row model.
module tb_led_row_sequencer;

    logic        clk = 1'b0;
    logic        rst, de, fs, lamp;
    logic [8:0]  x, y;
    logic [12:0] status;
    logic [9:0]  addr;
    logic [15:0] rom_on = '0, rom_off = '0;
    logic        o_de;
    logic [4:0]  o_r, o_b;
    logic [5:0]  o_g;

    int n_chk  = 0;
    int n_pass = 0;
    logic [16:0] e0, e1;

    always #5 clk = ~clk;

    led_row_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_x           (x),
        .i_y           (y),
        .i_de          (de),
        .i_frame_start (fs),
        .i_status      (status),
        .i_lamp_test   (lamp),
        .o_rom_addr    (addr),
        .i_rom_on      (rom_on),
        .i_rom_off     (rom_off),
        .o_de          (o_de),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b)
    );

    // Sprite contents: distinct and never zero, so on/off/black are all distinguishable.
    function automatic logic [15:0] on_val(input logic [9:0] a);
        return 16'hF800 ^ {6'd0, a};
    endfunction

    function automatic logic [15:0] off_val(input logic [9:0] a);
        return 16'h07E0 ^ {6'd0, a};
    endfunction

    // One-clock-latency ROM pair.
    always @(posedge clk) begin
        rom_on  <= on_val(addr);
        rom_off <= off_val(addr);
    end

    // Expected {o_de, RGB565} for one input pixel.
    function automatic logic [16:0] model(input int px, input int py, input bit pde,
                                          input logic [12:0] lit, input bit lmp,
                                          input bit kill, input bit zero);
        logic [9:0]  a;
        logic [15:0] pix;
        int          s;
        a   = {py[4:0], px[4:0]};
        pix = '0;
        if (pde && px >= 32 && px < 448 && py >= 96 && py < 128 && !kill) begin
            s   = (px - 32) / 32;
            pix = (lit[s] | lmp) ? on_val(a) : off_val(a);
        end
        if (zero) return '0;
        return {pde, pix};
    endfunction

    task automatic check(input string tag, input int px, input int py, input logic [16:0] exp);
        n_chk++;
        assert ({o_de, o_r, o_g, o_b} === exp) n_pass++;
        else $error("FAIL %s x=%0d y=%0d got %h expected %h", tag, px, py, {o_de, o_r, o_g, o_b}, exp);
    endtask

    // Drive one line x=0..465; output seen at negedge n belongs to the pixel driven at negedge n-2.
    task automatic run_line(input string tag, input int py, input logic [12:0] lit, input bit lmp,
                            input int de_lo, input int de_hi, input int chk_hi, input int rst_at);
        int x0p, x1p;
        bit kill, zero, pde;
        x0p = 0; x1p = 0; e0 = '0; e1 = '0;
        for (int n = 0; n < 466; n++) begin
            @(negedge clk);
            if (n >= 2 && x1p <= chk_hi) check(tag, x1p, py, e1);
            e1  = e0;
            x1p = x0p;
            kill = (rst_at >= 0) && (n >= rst_at - 1);
            zero = (rst_at >= 0) && (n >= rst_at - 1) && (n <= rst_at + 2);
            pde  = !(n >= de_lo && n <= de_hi);
            x    = 9'(n);
            y    = 9'(py);
            de   = pde;
            rst  = (rst_at >= 0) && (n >= rst_at) && (n <= rst_at + 2);
            e0   = model(n, py, pde, lit, lmp, kill, zero);
            x0p  = n;
        end
    endtask

    task automatic frame(input logic [12:0] st);
        @(negedge clk);
        status = st; fs = 1'b1; x = '0; y = '0; de = 1'b0;
        @(negedge clk);
        fs = 1'b0;
    endtask

    initial begin
        // Reset together with a frame_start carrying all-ones: reset must win.
        rst = 1'b1; fs = 1'b1; status = 13'h1FFF;
        x = '0; y = '0; de = 1'b0; lamp = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 0, 0, 17'h0);
        rst = 1'b0; fs = 1'b0;
        run_line("reset_wins_shadow0", 100, 13'h0000, 0, -1, -1, 999, -1);

        // Single lit slot 5 (x 192..223) plus band boundaries.
        frame(13'h0020);
        run_line("slot5_y100", 100, 13'h0020, 0, -1, -1, 999, -1);
        run_line("y95_outside", 95, 13'h0020, 0, -1, -1, 999, -1);
        run_line("y127_last", 127, 13'h0020, 0, -1, -1, 999, -1);
        run_line("y128_outside", 128, 13'h0020, 0, -1, -1, 999, -1);

        // Mid-frame status change only takes effect on the next frame.
        frame(13'h0001);
        run_line("slot0_y100", 100, 13'h0001, 0, -1, -1, 999, -1);
        status = 13'h1000;
        run_line("midframe_keep", 110, 13'h0001, 0, -1, -1, 999, -1);
        frame(13'h1000);
        run_line("nextframe_slot12", 110, 13'h1000, 0, -1, -1, 999, -1);

        // Lamp test overrides a dark status; removing it restores off sprites.
        frame(13'h0000);
        lamp = 1'b1;
        run_line("lamp_on", 105, 13'h0000, 1, -1, -1, 999, -1);
        lamp = 1'b0;
        run_line("lamp_off", 106, 13'h0000, 0, -1, -1, 999, -1);

        // DE gap inside the band, then alignment on the following line.
        frame(13'h1555);
        run_line("de_gap", 112, 13'h1555, 0, 200, 210, 210, -1);
        run_line("after_gap", 113, 13'h1555, 0, -1, -1, 999, -1);

        // Reset mid-scan: black immediately, stays black this line, shadow cleared afterwards.
        frame(13'h1FFF);
        run_line("rst_midline", 100, 13'h1FFF, 0, -1, -1, 999, 100);
        run_line("after_rst", 101, 13'h0000, 0, -1, -1, 999, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
